// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory read port, decoder valid/ready channel and redirect inputs.
// The master modport is the fetch unit. The slave modport is the memory/decoder side.
interface fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int NIB_W  = 4
);
    logic                run;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rw;
    logic [NIB_W-1:0]    mem_rdata;
    logic [2*NIB_W-1:0]  instr;
    logic [ADDR_W-1:0]   instr_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic                jump_valid;
    logic [ADDR_W-1:0]   jump_addr;

    modport master (
        input  run, mem_rdata, instr_ready, jump_valid, jump_addr,
        output mem_addr, mem_rw, instr, instr_pc, instr_valid
    );

    modport slave (
        output run, mem_rdata, instr_ready, jump_valid, jump_addr,
        input  mem_addr, mem_rw, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads two nibbles (PC, PC+1) from a 1-cycle-latency memory,
// assembles {hi, lo} and offers it on valid/ready. A jump redirects the PC from any state.
module fetch_unit #(
    parameter int                ADDR_W   = 4,
    parameter int                NIB_W    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {S_ADDR_HI, S_CAP_HI, S_CAP_LO, S_HOLD} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc, r_instr_pc;
    logic [NIB_W-1:0]    r_hi;
    logic [2*NIB_W-1:0]  r_instr;
    logic                r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_ADDR_HI;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ADDR_HI: if (bus.run) w_next = S_CAP_HI;
            S_CAP_HI:  w_next = S_CAP_LO;
            S_CAP_LO:  w_next = S_HOLD;
            S_HOLD:    if (bus.instr_ready) w_next = S_ADDR_HI;
            default:   w_next = S_ADDR_HI;
        endcase
        // A redirect overrides every other transition, including a same-cycle accept.
        if (bus.jump_valid) w_next = S_ADDR_HI;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_hi       <= '0;
            r_instr    <= '0;
            r_instr_pc <= RESET_PC;
            r_valid    <= 1'b0;
        end else if (bus.jump_valid) begin
            r_pc    <= bus.jump_addr;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_CAP_HI: r_hi <= bus.mem_rdata;
                S_CAP_LO: begin
                    r_instr    <= {r_hi, bus.mem_rdata};
                    r_instr_pc <= r_pc;
                    r_valid    <= 1'b1;
                end
                S_HOLD: if (bus.instr_ready) begin
                    r_pc    <= r_pc + ADDR_W'(2);
                    r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The low-nibble address goes out while the high nibble is being captured.
    assign bus.mem_addr    = (r_state == S_CAP_HI) ? r_pc + ADDR_W'(1) : r_pc;
    assign bus.mem_rw      = 1'b1;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer sitting directly upstream of the 16x4 `memory` block. It owns the program counter, drives `memory`'s address and rw inputs, and reads two consecutive nibbles: high nibble at PC, low nibble at PC+1. It assembles them into one 8-bit instruction and hands it to the decoder over a valid/ready handshake. Read-only: it never issues a write.

## Interface
Parameters:
- `ADDR_W`, 4, memory address width; PC width.
- `NIB_W`, 4, memory data width; instruction width is 2*NIB_W.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; not forwarded to `memory`.
- `run`  in  1  fetch enable; sampled only in S_ADDR_HI.
- `mem_addr`  out  ADDR_W  to `memory.address`.
- `mem_rw`  out  1  to `memory.rw`; constant 1 (read).
- `mem_rdata`  in  NIB_W  from `memory.read_data`.
- `instr`  out  2*NIB_W  assembled instruction, {hi, lo}.
- `instr_pc`  out  ADDR_W  address of the high nibble of `instr`.
- `instr_valid`  out  1  `instr` is stable and offered.
- `instr_ready`  in  1  decoder accepts when high with `instr_valid`.
- `jump_valid`  in  1  redirect request, one-cycle pulse or level.
- `jump_addr`  in  ADDR_W  redirect target.

## Operation
- `memory` read latency: address sampled at edge E, `read_data` valid after E, captured at E+1.
- PC arithmetic is modulo 2^ADDR_W. PC+1 and PC+2 wrap, e.g. PC=15 fetches 15 then 0, and the next PC is 1. Odd PCs are legal.
- `mem_addr` is combinational: PC+1 in S_CAP_HI, PC in all other states.
- States:
  - S_ADDR_HI: `instr_valid`=0. If `run`=1, go to S_CAP_HI; else stay.
  - S_CAP_HI: capture `mem_rdata` into hi. Go to S_CAP_LO.
  - S_CAP_LO: capture `mem_rdata` into lo. Load `instr`={hi, mem_rdata} and `instr_pc`=PC. Set `instr_valid`=1. Go to S_HOLD.
  - S_HOLD: `instr`, `instr_pc` and `instr_valid`=1 held stable. On `instr_ready`=1: PC<=PC+2, `instr_valid`<=0, go to S_ADDR_HI.
- Jump: when `jump_valid`=1 at an edge in any state:
  - PC<=`jump_addr`, `instr_valid`<=0, go to S_ADDR_HI.
  - Any partially fetched nibble is discarded.
  - Jump has priority over all other transitions.
- Jump and handshake in the same S_HOLD cycle: the offered instruction counts as accepted and PC takes `jump_addr`, not PC+2.
- `run`=0 only stalls at S_ADDR_HI. A fetch already in progress completes and is offered.
- Reset asserted at any time: immediate return to the reset state; in-flight fetch lost.

## Timing
- Reset values: state=S_ADDR_HI, PC=RESET_PC, `mem_addr`=RESET_PC, `mem_rw`=1, `instr`=0, `instr_pc`=RESET_PC, `instr_valid`=0.
- Latency: `instr_valid` rises 3 edges after leaving reset with `run`=1, counting edges E1..E3:
  - E1: S_ADDR_HI to S_CAP_HI.
  - E2: hi captured.
  - E3: lo captured, `instr_valid`=1.
- Throughput with `instr_ready` held high: one instruction per 4 cycles.
- After a jump, the first `instr_valid` comes 3 edges after the jump edge if `run`=1.
- `instr`/`instr_pc` never change while `instr_valid`=1, except on jump or reset.
- `mem_rw` is never 0, including during reset.

## Test plan
- Reset/idle: memory preloaded, `reset`=0 then 1, `run`=0 for 10 cycles -> `instr_valid`=0 throughout, `mem_addr`=0, `mem_rw`=1.
- Sequential fetch: mem[0..3]=A,5,3,C, `run`=1, `instr_ready`=1 -> `instr`=8'hA5 @pc 0, then 8'h3C @pc 2, each 4 cycles apart.
- Backpressure: `instr_ready`=0 for 6 cycles after the first valid -> 8'hA5 held stable with `instr_valid`=1, PC unchanged; ready=1 -> next fetch from address 2.
- Wrap-around: jump to 15, mem[15]=7, mem[0]=2 -> `instr`=8'h72, `instr_pc`=15; next fetch at address 1.
- Jump mid-fetch: `jump_valid` with `jump_addr`=8 asserted in S_CAP_HI, mem[8..9]=E,1 -> partial fetch dropped, `instr`=8'hE1 with `instr_pc`=8 three edges later.
- Async reset mid-fetch: `reset`=0 between edges in S_CAP_LO -> `instr_valid`=0 and `mem_addr`=RESET_PC immediately, without waiting for a clock edge.
